// File: rtl/counter_pkg.sv
// Shared constants and modulo arithmetic for the free-running counters.
package counter_pkg;

    localparam int              DEFAULT_WIDTH   = 4;
    localparam longint unsigned DEFAULT_MODULUS = 64'd16;
    localparam longint unsigned DEFAULT_STEP    = 64'd1;

    // Sum is kept one bit wider than the operands, so a + step never overflows
    // before the modulus is taken off.
    function automatic logic [31:0] mod_add(
        input logic [31:0] a,
        input logic [31:0] step,
        input logic [32:0] modulus
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, step};
        if (sum >= modulus) begin
            sum = sum - modulus;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count, rollover detect and terminal-count decode.
module counter_next
    import counter_pkg::*;
#(
    parameter int              WIDTH   = DEFAULT_WIDTH,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter longint unsigned STEP    = DEFAULT_STEP
) (
    input  logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_next,
    output logic             tc_next,
    output logic             wrap_next
);

    always_comb begin
        cnt_next  = WIDTH'(mod_add(32'(cnt), 32'(STEP), 33'(MODULUS)));
        // STEP < MODULUS, so the result is smaller exactly when the subtraction fired.
        wrap_next = (cnt_next < cnt);
        tc_next   = (cnt_next == WIDTH'(MODULUS - 64'd1));
    end

endmodule

// File: rtl/counter.sv
// Free-running modulo-MODULUS up counter with registered terminal-count and wrap pulse.
module counter
    import counter_pkg::*;
#(
    parameter int              WIDTH   = DEFAULT_WIDTH,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter longint unsigned STEP    = DEFAULT_STEP,
    parameter longint unsigned INIT    = 64'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(INIT);
    localparam logic             TC_INIT  = (INIT == MODULUS - 64'd1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter: WIDTH %0d outside 1..32", WIDTH);
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end
    if (STEP == 64'd0 || STEP >= MODULUS) begin : g_bad_step
        $error("counter: STEP %0d outside 1..MODULUS-1", STEP);
    end
    if (INIT >= MODULUS) begin : g_bad_init
        $error("counter: INIT %0d not below MODULUS", INIT);
    end

    // Declaration initialisers give defined outputs even if reset never arrives.
    logic [WIDTH-1:0] cnt_q  = CNT_INIT;
    logic             tc_q   = TC_INIT;
    logic             wrap_q = 1'b0;

    logic [WIDTH-1:0] cnt_next;
    logic             tc_next;
    logic             wrap_next;

    counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .STEP    (STEP)
    ) u_next (
        .cnt       (cnt_q),
        .cnt_next  (cnt_next),
        .tc_next   (tc_next),
        .wrap_next (wrap_next)
    );

    // rst_n is active-high; the name survives from older instantiations.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q  <= CNT_INIT;
            tc_q   <= TC_INIT;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_next;
            tc_q   <= tc_next;
            wrap_q <= wrap_next;
        end
    end

    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_counter.sv
// Directed and randomised checks of counter in default and modulo-10/step-3 configurations.
module tb_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cnt_a, cnt_b;
    logic       tc_a, tc_b, wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter u_dut_a (
        .clk   (clk),
        .rst_n (rst),
        .cnt   (cnt_a),
        .tc    (tc_a),
        .wrap  (wrap_a)
    );

    counter #(
        .WIDTH   (4),
        .MODULUS (10),
        .STEP    (3),
        .INIT    (0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst),
        .cnt   (cnt_b),
        .tc    (tc_b),
        .wrap  (wrap_b)
    );

    typedef struct {
        logic rst;
        int   ca;
        logic ta;
        logic wa;
        int   cb;
        logic tb;
        logic wb;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_with(input logic r);
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int c, input int t, input int w);
        check({tag, " cnt_a"},  int'(cnt_a),  c);
        check({tag, " tc_a"},   int'(tc_a),   t);
        check({tag, " wrap_a"}, int'(wrap_a), w);
    endtask

    int m_ca, m_cb, s;
    logic m_ta, m_wa, m_tb, m_wb;
    logic r;

    initial begin
        // Hand-computed: A is 0..15, B walks 0,3,6,9,2,5,8,1,4,7,0,...
        vecs[0]  = '{1'b0,  1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        vecs[1]  = '{1'b0,  2, 1'b0, 1'b0, 6, 1'b0, 1'b0};
        vecs[2]  = '{1'b0,  3, 1'b0, 1'b0, 9, 1'b1, 1'b0};
        vecs[3]  = '{1'b0,  4, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        vecs[4]  = '{1'b0,  5, 1'b0, 1'b0, 5, 1'b0, 1'b0};
        vecs[5]  = '{1'b0,  6, 1'b0, 1'b0, 8, 1'b0, 1'b0};
        vecs[6]  = '{1'b0,  7, 1'b0, 1'b0, 1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0,  8, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[8]  = '{1'b0,  9, 1'b0, 1'b0, 7, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 10, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 11, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        vecs[11] = '{1'b1,  0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[12] = '{1'b1,  0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[13] = '{1'b0,  1, 1'b0, 1'b0, 3, 1'b0, 1'b0};

        // Power-up without reset: defined values before the first edge.
        #1;
        check("powerup known a", int'($isunknown({cnt_a, tc_a, wrap_a})), 0);
        check("powerup known b", int'($isunknown({cnt_b, tc_b, wrap_b})), 0);
        check_a("powerup", 0, 0, 0);
        check("powerup cnt_b", int'(cnt_b), 0);

        foreach (vecs[i]) begin
            edge_with(vecs[i].rst);
            check($sformatf("vec%0d cnt_a", i),  int'(cnt_a),  vecs[i].ca);
            check($sformatf("vec%0d tc_a", i),   int'(tc_a),   int'(vecs[i].ta));
            check($sformatf("vec%0d wrap_a", i), int'(wrap_a), int'(vecs[i].wa));
            check($sformatf("vec%0d cnt_b", i),  int'(cnt_b),  vecs[i].cb);
            check($sformatf("vec%0d tc_b", i),   int'(tc_b),   int'(vecs[i].tb));
            check($sformatf("vec%0d wrap_b", i), int'(wrap_b), int'(vecs[i].wb));
        end

        // Rollover of A: currently 1, 14 edges reach 15.
        for (int i = 0; i < 14; i++) edge_with(1'b0);
        check_a("at15", 15, 1, 0);
        edge_with(1'b0);
        check_a("rollover", 0, 0, 1);
        edge_with(1'b0);
        check_a("after_roll", 1, 0, 0);

        // Reset mid-count at 9.
        for (int i = 0; i < 8; i++) edge_with(1'b0);
        check_a("at9", 9, 0, 0);
        edge_with(1'b1);
        check_a("mid_reset", 0, 0, 0);
        edge_with(1'b0);
        check_a("post_reset", 1, 0, 0);

        // Random reset pulses against a reference model.
        edge_with(1'b1);
        m_ca = 0; m_ta = 1'b0; m_wa = 1'b0;
        m_cb = 0; m_tb = 1'b0; m_wb = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            r = ($urandom_range(0, 15) == 0);
            edge_with(r);
            if (r) begin
                m_ca = 0; m_ta = 1'b0; m_wa = 1'b0;
                m_cb = 0; m_tb = 1'b0; m_wb = 1'b0;
            end else begin
                s = m_ca + 1;
                m_wa = (s >= 16);
                m_ca = m_wa ? s - 16 : s;
                m_ta = (m_ca == 15);
                s = m_cb + 3;
                m_wb = (s >= 10);
                m_cb = m_wb ? s - 10 : s;
                m_tb = (m_cb == 9);
            end
            if ({cnt_a, tc_a, wrap_a, cnt_b, tc_b, wrap_b} !==
                {4'(m_ca), m_ta, m_wa, 4'(m_cb), m_tb, m_wb}) begin
                check($sformatf("rand%0d a{cnt,tc,wrap}", i),
                      int'({cnt_a, tc_a, wrap_a}), int'({4'(m_ca), m_ta, m_wa}));
                check($sformatf("rand%0d b{cnt,tc,wrap}", i),
                      int'({cnt_b, tc_b, wrap_b}), int'({4'(m_cb), m_tb, m_wb}));
            end else begin
                checks++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
